// File: rtl/func_unit_pkg.sv
// rtl/func_unit_pkg.sv - function-select encodings and flag bundle for the pipelined function unit
package func_unit_pkg;

  typedef enum logic [3:0] {
    T_A    = 4'b0000,
    INC    = 4'b0001,
    ADD    = 4'b0010,
    ADDC   = 4'b0011,
    ADDNB  = 4'b0100,
    SUB    = 4'b0101,
    DEC    = 4'b0110,
    T_A2   = 4'b0111,
    AND_OP = 4'b1000,
    OR_OP  = 4'b1001,
    XOR_OP = 4'b1010,
    NOT_A  = 4'b1011,
    T_B    = 4'b1100,
    LSR    = 4'b1101,
    LSL    = 4'b1110,
    ASR    = 4'b1111
  } fs_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } flags_t;

endpackage

// File: rtl/func_unit_if.sv
// rtl/func_unit_if.sv - operand/result handshake bundle between issuer and function unit
interface func_unit_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       FS;
  logic [SHW-1:0]   SH;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             V;
  logic             C;
  logic             N;
  logic             Z;

  modport master (
    output flush, in_valid, FS, SH, A, B, out_ready,
    input  in_ready, out_valid, F, V, C, N, Z
  );

  modport slave (
    input  flush, in_valid, FS, SH, A, B, out_ready,
    output in_ready, out_valid, F, V, C, N, Z
  );

endinterface

// File: rtl/func_unit_core.sv
// rtl/func_unit_core.sv - combinational WIDTH-bit ALU/shifter producing result and V/C/N/Z
module func_unit_core
  import func_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [3:0]       fs,
  input  logic [SHW-1:0]   sh,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] f,
  output flags_t           flags
);

  logic [WIDTH-1:0] x;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl_t;
  logic [WIDTH:0]   shr_t;
  logic [WIDTH:0]   sra_t;
  logic             c;
  logic             v;

  always_comb begin
    x   = '0;
    cin = 1'b0;
    case (fs_e'(fs))
      INC:     cin = 1'b1;
      ADD:     x = b;
      ADDC:    begin x = b;  cin = 1'b1; end
      ADDNB:   x = ~b;
      SUB:     begin x = ~b; cin = 1'b1; end
      DEC:     x = '1;
      default: x = '0;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, x} + {{WIDTH{1'b0}}, cin};

  // One guard bit beyond the operand catches the last bit shifted out; it is 0 for SH=0.
  assign shl_t = {1'b0, a} << sh;
  assign shr_t = {a, 1'b0} >> sh;
  assign sra_t = $signed({a, 1'b0}) >>> sh;

  always_comb begin
    f = '0;
    c = 1'b0;
    v = 1'b0;
    case (fs_e'(fs))
      INC, ADD, ADDC, ADDNB, SUB, DEC: begin
        f = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == x[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      AND_OP:  f = a & b;
      OR_OP:   f = a | b;
      XOR_OP:  f = a ^ b;
      NOT_A:   f = ~a;
      T_B:     f = b;
      LSR:     begin f = shr_t[WIDTH:1];   c = shr_t[0];     end
      LSL:     begin f = shl_t[WIDTH-1:0]; c = shl_t[WIDTH]; end
      ASR:     begin f = sra_t[WIDTH:1];   c = sra_t[0];     end
      default: f = a;
    endcase
    flags = '{v: v, c: c, n: f[WIDTH-1], z: (f == '0)};
  end

endmodule

// File: rtl/func_unit_pipe.sv
// rtl/func_unit_pipe.sv - two-stage valid/ready pipelined function unit with flush
module func_unit_pipe
  import func_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  func_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             s1_valid;
  logic [3:0]       s1_fs;
  logic [SHW-1:0]   s1_sh;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;
  logic [WIDTH-1:0] f_q;
  flags_t           flags_q;
  logic [WIDTH-1:0] core_f;
  flags_t           core_flags;
  logic             adv1;
  logic             adv2;

  assign adv2        = ~s2_valid | bus.out_ready;
  assign adv1        = ~s1_valid | adv2;
  assign bus.in_ready = adv1 & ~bus.flush;

  func_unit_core #(.WIDTH(WIDTH)) u_core (
    .fs    (s1_fs),
    .sh    (s1_sh),
    .a     (s1_a),
    .b     (s1_b),
    .f     (core_f),
    .flags (core_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_fs    <= '0;
      s1_sh    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      f_q      <= '0;
      flags_q  <= '0;
    end else if (bus.flush) begin
      // Squash only the valids; stale result/flags stay visible but unqualified.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_fs <= bus.FS;
          s1_sh <= bus.SH;
          s1_a  <= bus.A;
          s1_b  <= bus.B;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          f_q     <= core_f;
          flags_q <= core_flags;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.F         = f_q;
  assign bus.V         = flags_q.v;
  assign bus.C         = flags_q.c;
  assign bus.N         = flags_q.n;
  assign bus.Z         = flags_q.z;

endmodule

// File: tb/tb_func_unit_pipe.sv
// tb/tb_func_unit_pipe.sv - scoreboard bench for func_unit_pipe at WIDTH=32 and WIDTH=8
module tb_func_unit_pipe;
  import func_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  logic [35:0] exp_q[$];
  logic [11:0] exp8_q[$];

  func_unit_if #(.WIDTH(32)) bus ();
  func_unit_if #(.WIDTH(8))  bus8 ();

  func_unit_pipe #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  func_unit_pipe #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] fs, input logic [4:0] sh, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] f_exp, input logic [3:0] fl_exp);
    bit ok = 0;
    bus.in_valid = 1'b1; bus.FS = fs; bus.SH = sh; bus.A = a; bus.B = b;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL issue_timeout: in_ready stayed 0 for fs=%b", fs);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back({f_exp, fl_exp});
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] f_exp, input logic [3:0] fl_exp);
    bit ok = 0;
    bus8.in_valid = 1'b1; bus8.FS = fs; bus8.SH = '0; bus8.A = a; bus8.B = b;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = bus8.in_ready;
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL issue8_timeout: in_ready stayed 0 for fs=%b", fs);
      bus8.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp8_q.push_back({f_exp, fl_exp});
    #1 bus8.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (exp8_q.size() == 0) && !bus.out_valid && !bus8.out_valid;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding", exp_q.size(), exp8_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: F=%h with empty scoreboard", bus.F);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if (bus.F !== e[35:4] || {bus.V, bus.C, bus.N, bus.Z} !== e[3:0]) begin
          fails++;
          $display("FAIL result32: F=%h VCNZ=%b expected F=%h VCNZ=%b",
                   bus.F, {bus.V, bus.C, bus.N, bus.Z}, e[35:4], e[3:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      checks++;
      if (exp8_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result8: F=%h with empty scoreboard", bus8.F);
      end else begin
        logic [11:0] e;
        e = exp8_q.pop_front();
        if (bus8.F !== e[11:4] || {bus8.V, bus8.C, bus8.N, bus8.Z} !== e[3:0]) begin
          fails++;
          $display("FAIL result8: F=%h VCNZ=%b expected F=%h VCNZ=%b",
                   bus8.F, {bus8.V, bus8.C, bus8.N, bus8.Z}, e[11:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.FS = '0; bus.SH = '0; bus.A = '0; bus.B = '0;
    bus.out_ready = 1;
    bus8.flush = 0; bus8.in_valid = 0; bus8.FS = '0; bus8.SH = '0; bus8.A = '0; bus8.B = '0;
    bus8.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_F", bus.F, 32'd0);
    chk("reset_flags", {28'd0, bus.V, bus.C, bus.N, bus.Z}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back directed vectors, expected {F, VCNZ} worked by hand.
    issue(ADD,    0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1010);
    issue(SUB,    0, 32'd5,        32'd5,        32'h0,        4'b0101);
    issue(DEC,    0, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0010);
    issue(LSR,    1, 32'h80000001, 32'h0,        32'h40000000, 4'b0100);
    issue(ASR,    1, 32'h80000001, 32'h0,        32'hC0000000, 4'b0110);
    issue(LSL,    1, 32'h80000001, 32'h0,        32'h00000002, 4'b0100);
    issue(LSR,    0, 32'h80000001, 32'h0,        32'h80000001, 4'b0010);
    issue(LSL,    0, 32'h80000001, 32'h0,        32'h80000001, 4'b0010);
    issue(ASR,    0, 32'h80000001, 32'h0,        32'h80000001, 4'b0010);
    issue(AND_OP, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010);
    issue(XOR_OP, 0, 32'h1234,     32'h1234,     32'h0,        4'b0001);
    issue(NOT_A,  0, 32'hFFFFFFFF, 32'h0,        32'h0,        4'b0001);
    issue(T_B,    0, 32'h0,        32'd5,        32'd5,        4'b0000);
    issue(INC,    0, 32'hFFFFFFFF, 32'h0,        32'h0,        4'b0101);
    issue(T_A2,   0, 32'h00000077, 32'h1,        32'h77,       4'b0000);
    wait_drain();

    // Backpressure: only two ops fit while the consumer stalls.
    @(posedge clk); #1 bus.out_ready = 0;
    issue(ADD, 0, 32'd1,        32'd2,        32'd3,  4'b0000);
    issue(ADD, 0, 32'hFFFFFFFF, 32'd1,        32'd0,  4'b0101);
    fork
      begin
        issue(ADD, 0, 32'h80000000, 32'h80000000, 32'd0,  4'b1101);
        issue(ADD, 0, 32'd10,       32'd20,       32'd30, 4'b0000);
      end
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_F_stable", bus.F, 32'd3);
      chk("bp_flags_stable", {28'd0, bus.V, bus.C, bus.N, bus.Z}, 32'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1;
    wait_drain();

    // Flush with both stages full; the op offered alongside must be refused.
    @(posedge clk); #1 bus.out_ready = 0;
    issue(ADD, 0, 32'd100, 32'd1, 32'd101, 4'b0000);
    issue(ADD, 0, 32'd200, 32'd1, 32'd201, 4'b0000);
    bus.flush = 1; bus.in_valid = 1; bus.FS = ADD; bus.A = 32'd300; bus.B = 32'd1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1 bus.out_ready = 1;
    issue(OR_OP, 0, 32'hA0, 32'h05, 32'hA5, 4'b0000);
    @(negedge clk);
    chk("lat_cycle1_invalid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {31'd0, bus.out_valid}, 32'd1);
    wait_drain();

    // Reset while a result is being held.
    @(posedge clk); #1 bus.out_ready = 0;
    issue(ADD, 0, 32'd7, 32'd8, 32'd15, 4'b0000);
    repeat (2) @(negedge clk);
    chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    bus.out_ready = 1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_F", bus.F, 32'd0);
    chk("rst_flags", {28'd0, bus.V, bus.C, bus.N, bus.Z}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // WIDTH=8 instance.
    @(posedge clk); #1;
    issue8(INC, 8'hFF, 8'h00, 8'h00, 4'b0101);
    issue8(ADD, 8'h7F, 8'h01, 8'h80, 4'b1010);
    issue8(SUB, 8'h00, 8'h01, 8'hFF, 4'b0010);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
